sp_window_3x3: RTL
==================

# sp_window_3x3

Streaming 3x3 neighbourhood generator for the salt-and-pepper filter datapath. It sits directly upstream of the pixel-select mux and median/replacement logic. It accepts a raster pixel stream, buffers two lines, and emits one 9-pixel window per image position. Out-of-image neighbours are handled by a fixed border rule. Valid/ready handshakes on both sides; full backpressure.

## Interface
- PIX_W, 9, pixel word width (matches downstream mux width)
- IMG_W, 256, pixels per row (>= 2)
- IMG_H, 256, rows per frame (>= 2)
- clk  in  1  single clock, rising edge
- rst  in  1  reset; **one clock; reset is synchronous and active-high**
- in_valid  in  1  input pixel valid
- in_ready  out  1  block accepts in_pix this cycle
- in_pix  in  PIX_W  raster-order pixel
- out_valid  out  1  window valid
- out_ready  in  1  downstream accepts window
- out_win  out  9*PIX_W  window; p[k] at [k*PIX_W +: PIX_W], k = 3*dy + dx, p[0] top-left, p[4] centre, p[8] bottom-right
- out_sof  out  1  window centre is (0,0)
- out_eol  out  1  window centre column is IMG_W-1
- out_eof  out  1  window centre is (IMG_H-1, IMG_W-1)

## Operation
- Virtual grid of (IMG_H+1) x (IMG_W+1) steps, indexed (i,j). Real pixels occupy i<IMG_H, j<IMG_W. Column j=IMG_W and row i=IMG_H are pad steps, generated internally with no input consumed.
- A step at (i,j) with i>=1 and j>=1 emits the window centred at (i-1, j-1).
- FSM:
  - RUN: one step per accepted pixel. After j=IMG_W-1, go to PADCOL.
  - PADCOL: one pad step. Then go to RUN, or to PADROW if i=IMG_H-1.
  - PADROW: IMG_W+1 pad steps. Then reset counters to (0,0) and go to RUN for the next frame.
- Step enable: !out_valid || out_ready, and additionally in_valid when in RUN.
- in_ready = (state==RUN) && (!out_valid || out_ready).
- Two line buffers, depth IMG_W+1, plus a 3x3 column shift register. Pad steps write a 0 word.
- Border rule (default, zero): any neighbour with row or column outside the image outputs 0. This is applied by position masks, never by buffer contents.
- Output register: out_win and the flags load on an emitting step. out_valid is held, and out_win and the flags are stable, while !out_ready.
- Counters: $clog2(IMG_W+1) and $clog2(IMG_H+1) bits; wrap only via the PADROW exit.
- Reset values:
  - out_valid=0, out_sof=0, out_eol=0, out_eof=0, out_win=0.
  - in_ready=0 during the rst cycle.
  - State=RUN, counters=(0,0).
  - Line buffer contents are not cleared.
- Reset mid-frame: the partial frame is discarded, the pending window is dropped, and the next accepted pixel is (0,0).

## Timing
- Window (r,c) is presented the cycle after the step at (r+1, c+1):
  - c < IMG_W-1: the step that accepts pixel (r+1, c+1).
  - c = IMG_W-1: the PADCOL step.
  - r = IMG_H-1: a PADROW step.
- First window: cycle after pixel (1,1) is accepted.
- Per row: in_ready low exactly 1 cycle after the row's last pixel (PADCOL), with no stall present.
- End of frame: in_ready low IMG_W+2 cycles (PADCOL plus PADROW), with no stall present.
- Throughput: 1 window/cycle in RUN, with no bubbles except pad steps.
- Simultaneous out_ready and step: the old window leaves and the new one loads in the same cycle.

## Configuration
- SP_BORDER_REPLICATE_EN defined: out-of-image neighbours take the nearest in-image pixel (row/column clamp; corners clamp both).
- Not defined: out-of-image neighbours are zero.
- Handshake, timing and pad steps are identical in both builds.

## Structure
- Package sp_win_pkg holds:
  - the FSM state enum (RUN, PADCOL, PADROW)
  - window index constants (WIN_TL..WIN_BR, WIN_C=4)
  - the default PIX_W
- Sub-module sp_line_buf: synchronous-write, registered-read RAM, depth IMG_W+1. Instantiated twice.

## Test plan
Unless stated otherwise, IMG_W=4, IMG_H=3, pixel(r,c) = 4r+c+1, and out_ready=1.
- **Ramp frame:** exactly 12 windows in raster order; first out_valid is the cycle after the 6th pixel is accepted; window (1,1) = {1,2,3,5,6,7,9,10,11}.
- **Zero border:** window (0,0) = {0,0,0,0,1,2,0,5,6} with out_sof=1; window (2,3) = {7,8,0,11,12,0,0,0,0} with out_eol=1 and out_eof=1.
- **SP_BORDER_REPLICATE_EN:** window (0,0) = {1,1,2,1,1,2,5,5,6}; window (2,3) = {7,8,8,11,12,12,11,12,12}.
- **Backpressure:** out_ready low for 5 cycles while window (1,2) is presented. out_win is stable, in_ready=0, and the output sequence is identical to the ramp test.
- **Pad timing:** continuous in_valid. in_ready is low 1 cycle after pixels 4 and 8, and 6 cycles after pixel 12. The next frame's first pixel is accepted immediately after and is treated as (0,0).
- **Reset mid-frame:** assert rst after 7 pixels. out_valid=0 the next cycle; a fresh 12-pixel frame then reproduces the ramp-test output exactly.

Source files
------------

// File: rtl/sp_win_pkg.sv
// Shared types and constants for the 3x3 neighbourhood window generator.
// Window index k = 3*dy + dx, top-left first, centre at WIN_C.
package sp_win_pkg;

    localparam int PIX_W_DEFAULT = 9;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PADCOL = 2'd1,
        PADROW = 2'd2
    } state_t;

    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_C  = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;

endpackage

// File: rtl/sp_line_buf.sv
// One image line of pixel storage: synchronous write, registered read.
// Contents are never cleared; the window logic masks stale data by position.
module sp_line_buf #(
    parameter int W     = 9,
    parameter int DEPTH = 257,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_reg <= mem[raddr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/sp_window_3x3.sv
// Streaming 3x3 window generator with two line buffers and pad steps.
// Border rule: zero by default; SP_BORDER_REPLICATE_EN selects edge replication.
module sp_window_3x3
    import sp_win_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEFAULT,
    parameter int IMG_W = 256,
    parameter int IMG_H = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIX_W-1:0]   in_pix,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [9*PIX_W-1:0] out_win,
    output logic               out_sof,
    output logic               out_eol,
    output logic               out_eof
);

    localparam int JW = $clog2(IMG_W + 1);
    localparam int IW = $clog2(IMG_H + 1);
    localparam logic [JW-1:0] J_LAST = JW'(IMG_W - 1);
    localparam logic [JW-1:0] J_PAD  = JW'(IMG_W);
    localparam logic [IW-1:0] I_LAST = IW'(IMG_H - 1);
    localparam logic [IW-1:0] I_PAD  = IW'(IMG_H);

    state_t               state_reg;
    logic [JW-1:0]        j_reg;
    logic [IW-1:0]        i_reg;
    logic [JW-1:0]        j_adv;
    logic [JW-1:0]        rd_addr;
    logic                 can_adv;
    logic                 step;
    logic                 emit;
    logic [PIX_W-1:0]     step_pix;
    logic [PIX_W-1:0]     lb1_rd;
    logic [PIX_W-1:0]     lb2_rd;
    logic [PIX_W-1:0]     col_reg [2][3];
    logic [PIX_W-1:0]     raw [9];
    logic [PIX_W-1:0]     win_next [9];
    logic [9*PIX_W-1:0]   win_flat;
    logic                 top_edge;
    logic                 bot_edge;
    logic                 left_edge;
    logic                 right_edge;

    logic                 out_valid_reg;
    logic [9*PIX_W-1:0]   out_win_reg;
    logic                 out_sof_reg;
    logic                 out_eol_reg;
    logic                 out_eof_reg;

    assign can_adv  = !out_valid_reg || out_ready;
    assign step     = !rst && can_adv && ((state_reg != RUN) || in_valid);
    assign in_ready = !rst && (state_reg == RUN) && can_adv;
    assign step_pix = (state_reg == RUN) ? in_pix : '0;
    assign emit     = (i_reg != '0) && (j_reg != '0);

    // Column after the pad column wraps to 0; PADCOL always sits at J_PAD.
    assign j_adv = (j_reg == J_PAD) ? '0 : j_reg + 1'b1;

    // Read port runs one step ahead so the registered read lands on the current column.
    assign rd_addr = rst ? '0 : (step ? j_adv : j_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
            i_reg     <= '0;
            j_reg     <= '0;
        end else if (step) begin
            case (state_reg)
                RUN: begin
                    j_reg <= j_adv;
                    if (j_reg == J_LAST) begin
                        state_reg <= PADCOL;
                    end
                end
                PADCOL: begin
                    j_reg <= '0;
                    if (i_reg == I_LAST) begin
                        i_reg     <= I_PAD;
                        state_reg <= PADROW;
                    end else begin
                        i_reg     <= i_reg + 1'b1;
                        state_reg <= RUN;
                    end
                end
                PADROW: begin
                    j_reg <= j_adv;
                    if (j_reg == J_PAD) begin
                        i_reg     <= '0;
                        state_reg <= RUN;
                    end
                end
                default: begin
                    state_reg <= RUN;
                end
            endcase
        end
    end

    sp_line_buf #(
        .W     (PIX_W),
        .DEPTH (IMG_W + 1),
        .AW    (JW)
    ) u_lb1 (
        .clk   (clk),
        .we    (step),
        .waddr (j_reg),
        .wdata (step_pix),
        .raddr (rd_addr),
        .rdata (lb1_rd)
    );

    sp_line_buf #(
        .W     (PIX_W),
        .DEPTH (IMG_W + 1),
        .AW    (JW)
    ) u_lb2 (
        .clk   (clk),
        .we    (step),
        .waddr (j_reg),
        .wdata (lb1_rd),
        .raddr (rd_addr),
        .rdata (lb2_rd)
    );

    // Two previous columns of the neighbourhood; the third is the incoming one.
    always_ff @(posedge clk) begin
        if (step) begin
            col_reg[0]    <= col_reg[1];
            col_reg[1][0] <= lb2_rd;
            col_reg[1][1] <= lb1_rd;
            col_reg[1][2] <= step_pix;
        end
    end

    assign raw[WIN_TL] = col_reg[0][0];
    assign raw[WIN_TC] = col_reg[1][0];
    assign raw[WIN_TR] = lb2_rd;
    assign raw[WIN_ML] = col_reg[0][1];
    assign raw[WIN_C]  = col_reg[1][1];
    assign raw[WIN_MR] = lb1_rd;
    assign raw[WIN_BL] = col_reg[0][2];
    assign raw[WIN_BC] = col_reg[1][2];
    assign raw[WIN_BR] = step_pix;

    // Centre is (i-1, j-1); edges are decided from counters, never from buffer data.
    assign top_edge   = (i_reg == IW'(1));
    assign bot_edge   = (i_reg == I_PAD);
    assign left_edge  = (j_reg == JW'(1));
    assign right_edge = (j_reg == J_PAD);

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_win
            localparam int DY = gi / 3;
            localparam int DX = gi % 3;
            logic row_out;
            logic col_out;
            assign row_out = ((DY == 0) && top_edge) || ((DY == 2) && bot_edge);
            assign col_out = ((DX == 0) && left_edge) || ((DX == 2) && right_edge);
`ifdef SP_BORDER_REPLICATE_EN
            logic [1:0] sdy;
            logic [1:0] sdx;
            logic [3:0] sidx;
            assign sdy  = row_out ? 2'd1 : 2'(DY);
            assign sdx  = col_out ? 2'd1 : 2'(DX);
            assign sidx = ({2'b00, sdy} * 4'd3) + {2'b00, sdx};
            assign win_next[gi] = raw[sidx];
`else
            assign win_next[gi] = (row_out || col_out) ? '0 : raw[gi];
`endif
            assign win_flat[gi*PIX_W +: PIX_W] = win_next[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_win_reg   <= '0;
            out_sof_reg   <= 1'b0;
            out_eol_reg   <= 1'b0;
            out_eof_reg   <= 1'b0;
        end else if (step && emit) begin
            out_valid_reg <= 1'b1;
            out_win_reg   <= win_flat;
            out_sof_reg   <= top_edge && left_edge;
            out_eol_reg   <= right_edge;
            out_eof_reg   <= bot_edge && right_edge;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_win   = out_win_reg;
    assign out_sof   = out_sof_reg;
    assign out_eol   = out_eol_reg;
    assign out_eof   = out_eof_reg;

endmodule
